gpio_out: RTL

- General-purpose output block. The CPU bus writes bytes into per-port holding registers, and those registers drive external output ports.
- Each port has a valid/ack handshake toward the external consumer. A CPU write to a port whose previous byte is still unconsumed stalls until the consumer acknowledges it.
- Sits on the CPU byte bus with the same read/write/ready_r/ready_w/address/data_in/data_out interface as the other peripherals. It is the output counterpart of the general input block.

---
 rtl/gpio_out_if.sv | 30 +++
 rtl/gpio_out.sv | 116 +++++++++++
 2 files changed

// File: rtl/gpio_out_if.sv
// CPU byte-bus interface shared by the peripherals.
//   address  : port/register select (ADDR_W bits)
//   data_in  : CPU write data
//   data_out : registered read data
//   read     : read request, held until ready_r
//   write    : write request, held until ready_w
//   ready_r  : read complete
//   ready_w  : write complete
// The master modport is the CPU side; the slave modport is the peripheral side.
interface gpio_out_if #(
    parameter int ADDR_W = 1
);
    logic [ADDR_W-1:0] address;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic              ready_r;
    logic              ready_w;

    modport master (
        output address, data_in, read, write,
        input  data_out, ready_r, ready_w
    );

    modport slave (
        input  address, data_in, read, write,
        output data_out, ready_r, ready_w
    );
endinterface

// File: rtl/gpio_out.sv
// General-purpose output block. CPU writes land in per-port holding registers
// that drive port_out; each port has a valid/ack handshake toward its consumer.
// A write to a port whose previous byte has not been consumed stalls until the
// consumer acknowledges it.
//   clk, reset : clock (posedge) and synchronous active-high reset
//   bus        : CPU byte bus (slave side)
//   port_out   : port i byte on [i*8+7 : i*8], registered
//   port_valid : port i holds an unconsumed byte
//   port_ack   : consumer takes port i byte this cycle
// Address map: 0..size-1 holding registers, size = status (port_valid),
// anything above reads as 0x00 and swallows writes.
module gpio_out #(
    parameter int size_addr = 0,
    parameter int size      = 1
) (
    input  logic              clk,
    input  logic              reset,
    gpio_out_if.slave         bus,
    output logic [size*8-1:0] port_out,
    output logic [size-1:0]   port_valid,
    input  logic [size-1:0]   port_ack
);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DONE} w_state_t;

    w_state_t    state;
    w_state_t    state_next;
    logic [7:0]  holding [size];
    logic [31:0] sel;
    logic        in_range;
    logic        is_status;
    logic        slot_free;
    logic        accept;
    logic [7:0]  rd_mux;

    // With no address bits the single port is always selected.
    always_comb begin
        sel       = (size_addr == 0) ? 32'd0 : 32'(bus.address);
        in_range  = sel < 32'(size);
        is_status = sel == 32'(size);
    end

    // A slot is free if empty or being drained this very cycle.
    always_comb begin
        slot_free = 1'b0;
        for (int i = 0; i < size; i++) begin
            if (sel == 32'(i)) slot_free = !port_valid[i] || port_ack[i];
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (in_range) begin
            for (int i = 0; i < size; i++) begin
                if (sel == 32'(i)) rd_mux = holding[i];
            end
        end else if (is_status) begin
            for (int i = 0; i < size; i++) rd_mux[i] = port_valid[i];
        end
    end

    // Write FSM: W_IDLE and W_WAIT both evaluate the current request; only
    // W_DONE ignores write until it drops, so a held write is taken once.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            W_IDLE, W_WAIT: begin
                if (!bus.write) begin
                    state_next = W_IDLE;
                end else if (!in_range) begin
                    state_next = W_DONE;        // discard, but complete the cycle
                end else if (slot_free) begin
                    accept     = 1'b1;
                    state_next = W_DONE;
                end else begin
                    state_next = W_WAIT;
                end
            end
            W_DONE: begin
                if (!bus.write) state_next = W_IDLE;
            end
            default: state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= W_IDLE;
            bus.ready_w  <= 1'b0;
            bus.ready_r  <= 1'b0;
            bus.data_out <= 8'h00;
            port_valid   <= '0;
            for (int i = 0; i < size; i++) holding[i] <= 8'h00;
        end else begin
            state       <= state_next;
            bus.ready_w <= (state_next == W_DONE);
            bus.ready_r <= bus.read;
            if (bus.read) bus.data_out <= rd_mux;
            // A simultaneous accept overrides the consumer's ack on that slot.
            for (int i = 0; i < size; i++) begin
                if (accept && sel == 32'(i)) begin
                    holding[i]    <= bus.data_in;
                    port_valid[i] <= 1'b1;
                end else if (port_ack[i]) begin
                    port_valid[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < size; g++) begin : g_port
        assign port_out[g*8 +: 8] = holding[g];
    end

endmodule
